// File: rtl/audio_adc_rx_if.sv
// audio_adc_rx_if
// Output bus of the audio ADC receiver: one stereo frame per sample period.
//   tick       1   one-cycle pulse, new frame valid on out_L/out_R
//   out_L      32  signed left sample, left-aligned
//   out_R      32  signed right sample, left-aligned
//   frame_err  1   one-cycle pulse on a malformed word
// Modports: master (driven by the receiver), slave (DSP consumer).
`timescale 1ns/1ps

interface audio_adc_rx_if;
    logic        tick;
    logic [31:0] out_L;
    logic [31:0] out_R;
    logic        frame_err;

    modport master (output tick, output out_L, output out_R, output frame_err);
    modport slave  (input  tick, input  out_L, input  out_R, input  frame_err);
endinterface

// File: rtl/audio_adc_rx.sv
// audio_adc_rx
// Deserialises the codec ADC I2S stream (BCLK/ADCLRCK/ADCDAT, asynchronous to
// CLOCK_50) into one stereo frame per sample period. All logic runs on
// CLOCK_50; the codec signals are synchronised and edge-detected, never used
// as clocks.
// Ports:
//   CLOCK_50     in   system clock, sole clock domain
//   reset_n      in   asynchronous active-low reset
//   enable       in   0 forces the FSM to IDLE, no ticks, outputs hold
//   AUD_BCLK     in   codec bit clock (async)
//   AUD_ADCLRCK  in   codec frame clock, low = left word (async)
//   AUD_ADCDAT   in   codec serial data, MSB first (async)
//   rx_bus       master modport of audio_adc_rx_if (tick/out_L/out_R/frame_err)
// Optional feature: define AUDIO_RX_DC_BLOCK_EN to insert a first-order DC
// blocker (pole shift DC_K) after the deserialiser; it adds one cycle of
// latency to tick and the outputs.
`timescale 1ns/1ps

module audio_adc_rx #(
    parameter int DATA_W  = 24,
    parameter int SYNC_FF = 2
`ifdef AUDIO_RX_DC_BLOCK_EN
    ,
    parameter int DC_K    = 10
`endif
) (
    input  logic           CLOCK_50,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           AUD_BCLK,
    input  logic           AUD_ADCLRCK,
    input  logic           AUD_ADCDAT,
    audio_adc_rx_if.master rx_bus
);

    typedef enum logic [2:0] {
        IDLE, L_SKIP, L_SHIFT, R_WAIT, R_SKIP, R_SHIFT, DONE, L_WAIT
    } state_t;

    localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);

    logic [SYNC_FF-1:0] bclk_sync, lrck_sync, data_sync;
    logic               bclk_d, lrck_d;
    logic               bclk_s, lrck_s, data_s;
    logic               bclk_rise, lrck_rise, lrck_fall;

    state_t             state, state_nxt;
    logic [5:0]         bit_cnt, cnt_nxt;
    logic [DATA_W-1:0]  shift_l, shift_r, shl_nxt, shr_nxt;
    logic               err_nxt, done_nxt;
    logic               err_q, done_q;
    logic [31:0]        samp_l, samp_r, fmt_l, fmt_r;

    assign bclk_s    = bclk_sync[SYNC_FF-1];
    assign lrck_s    = lrck_sync[SYNC_FF-1];
    assign data_s    = data_sync[SYNC_FF-1];
    assign bclk_rise = bclk_s & ~bclk_d;
    assign lrck_rise = lrck_s & ~lrck_d;
    assign lrck_fall = ~lrck_s & lrck_d;

    // Synchronisers plus one extra stage for edge detection. Data shares the
    // same depth as BCLK so the sampled bit lines up with the detected rise.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            data_sync <= '0;
            bclk_d    <= 1'b0;
            lrck_d    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_FF-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_FF-2:0], AUD_ADCLRCK};
            data_sync <= {data_sync[SYNC_FF-2:0], AUD_ADCDAT};
            bclk_d    <= bclk_s;
            lrck_d    <= lrck_s;
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and shift logic. LRCK edges take priority over BCLK rises:
    // an edge in the middle of a word is a framing error. A fall always
    // restarts a left word at once so the receiver resyncs without losing a
    // frame; any other misplaced edge drops back to IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shl_nxt   = shift_l;
        shr_nxt   = shift_r;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lrck_fall) state_nxt = L_SKIP;
                end
                L_SKIP, L_SHIFT: begin
                    if (lrck_fall) begin
                        err_nxt   = 1'b1;
                        state_nxt = L_SKIP;
                    end else if (lrck_rise) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (bclk_rise) begin
                        if (state == L_SKIP) begin
                            cnt_nxt   = '0;
                            state_nxt = L_SHIFT;
                        end else begin
                            shl_nxt = {shift_l[DATA_W-2:0], data_s};
                            cnt_nxt = bit_cnt + 6'd1;
                            if (bit_cnt == LAST_BIT) state_nxt = R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (lrck_rise) begin
                        state_nxt = R_SKIP;
                    end else if (lrck_fall) begin
                        err_nxt   = 1'b1;
                        state_nxt = L_SKIP;
                    end
                end
                R_SKIP, R_SHIFT: begin
                    if (lrck_fall) begin
                        err_nxt   = 1'b1;
                        state_nxt = L_SKIP;
                    end else if (lrck_rise) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (bclk_rise) begin
                        if (state == R_SKIP) begin
                            cnt_nxt   = '0;
                            state_nxt = R_SHIFT;
                        end else begin
                            shr_nxt = {shift_r[DATA_W-2:0], data_s};
                            cnt_nxt = bit_cnt + 6'd1;
                            if (bit_cnt == LAST_BIT) begin
                                done_nxt  = 1'b1;
                                state_nxt = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_nxt = lrck_fall ? L_SKIP : L_WAIT;
                end
                L_WAIT: begin
                    if (lrck_fall) begin
                        state_nxt = L_SKIP;
                    end else if (lrck_rise) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Left-align the codec word into 32 bits; works for DATA_W up to 32.
    always_comb begin
        fmt_l = '0;
        fmt_r = '0;
        fmt_l[31 -: DATA_W] = shift_l;
        fmt_r[31 -: DATA_W] = shr_nxt;
    end

    // Shift registers, bit counter and the registered raw frame. The raw
    // frame is captured in the same cycle the last right bit arrives, so
    // tick and both samples appear together on the following cycle.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shift_l <= '0;
            shift_r <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            samp_l  <= '0;
            samp_r  <= '0;
        end else begin
            bit_cnt <= cnt_nxt;
            shift_l <= shl_nxt;
            shift_r <= shr_nxt;
            err_q   <= err_nxt;
            done_q  <= done_nxt;
            if (done_nxt) begin
                samp_l <= fmt_l;
                samp_r <= fmt_r;
            end
        end
    end

`ifdef AUDIO_RX_DC_BLOCK_EN
    logic signed [31:0] x_prev_l, x_prev_r, y_prev_l, y_prev_r;
    logic signed [31:0] y_l_nxt, y_r_nxt;
    logic [31:0]        dc_l, dc_r;
    logic               tick_dc;

    // y = x - x_prev + y_prev - (y_prev >>> DC_K) with 40-bit headroom,
    // saturated back into the 32-bit output range.
    function automatic logic signed [31:0] dc_step(
        input logic signed [31:0] x,
        input logic signed [31:0] xp,
        input logic signed [31:0] yp
    );
        logic signed [39:0] xe, xpe, ype, ysh, y;
        xe  = x;
        xpe = xp;
        ype = yp;
        ysh = yp >>> DC_K;
        y   = xe - xpe + ype - ysh;
        if (y > 40'sh00_7FFF_FFFF) begin
            dc_step = 32'sh7FFF_FFFF;
        end else if (y < 40'shFF_8000_0000) begin
            dc_step = 32'sh8000_0000;
        end else begin
            dc_step = y[31:0];
        end
    endfunction

    assign y_l_nxt = dc_step(samp_l, x_prev_l, y_prev_l);
    assign y_r_nxt = dc_step(samp_r, x_prev_r, y_prev_r);

    // Filter state only advances on accepted frames.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            x_prev_l <= '0;
            x_prev_r <= '0;
            y_prev_l <= '0;
            y_prev_r <= '0;
            dc_l     <= '0;
            dc_r     <= '0;
            tick_dc  <= 1'b0;
        end else begin
            tick_dc <= done_q;
            if (done_q) begin
                x_prev_l <= samp_l;
                x_prev_r <= samp_r;
                y_prev_l <= y_l_nxt;
                y_prev_r <= y_r_nxt;
                dc_l     <= y_l_nxt;
                dc_r     <= y_r_nxt;
            end
        end
    end

    assign rx_bus.tick  = tick_dc;
    assign rx_bus.out_L = dc_l;
    assign rx_bus.out_R = dc_r;
`else
    assign rx_bus.tick  = done_q;
    assign rx_bus.out_L = samp_l;
    assign rx_bus.out_R = samp_r;
`endif

    assign rx_bus.frame_err = err_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx
// Directed bench for audio_adc_rx in its default (raw, no DC blocker) build.
// Drives an I2S stream (LRCK and data change on BCLK fall, MSB on the second
// BCLK rise after each LRCK edge, 32 BCLKs per channel) and checks frames,
// framing errors, reset and enable behaviour against hand-computed values.
`timescale 1ns/1ps

module tb_audio_adc_rx;

    logic CLOCK_50 = 1'b0;
    logic reset_n;
    logic enable;
    logic bclk;
    logic lrck;
    logic dat;

    int tests_run  = 0;
    int fail_count = 0;
    int tick_count = 0;
    int err_count  = 0;
    int t0;
    int e0;
    int bclk_half  = 163;

    audio_adc_rx_if rx_bus ();

    audio_adc_rx dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .enable      (enable),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .rx_bus      (rx_bus)
    );

    // 50 MHz system clock.
    always #10 CLOCK_50 = ~CLOCK_50;

    // Count tick and frame_err cycles away from the active edge.
    always @(negedge CLOCK_50) begin
        if (rx_bus.tick === 1'b1) tick_count++;
        if (rx_bus.frame_err === 1'b1) err_count++;
    end

    // One I2S channel slot of nbits BCLK periods; bit i (1..24) carries
    // word[24-i], so the MSB lands on the second rise after the LRCK edge.
    task automatic i2s_slot(input logic lr, input logic [23:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bclk = 1'b0;
            if (i == 0) lrck = lr;
            dat = (i >= 1 && i <= 24) ? word[24-i] : 1'b0;
            #(bclk_half);
            bclk = 1'b1;
            #(bclk_half);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] left, input logic [23:0] right);
        i2s_slot(1'b0, left, 32);
        i2s_slot(1'b1, right, 32);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        bclk    = 1'b0;
        lrck    = 1'b1;
        dat     = 1'b0;

        // Reset state.
        idle_cycles(5);
        checkOutput("reset_tick", {31'b0, rx_bus.tick}, 32'd0);
        checkOutput("reset_err", {31'b0, rx_bus.frame_err}, 32'd0);
        checkOutput("reset_outL", rx_bus.out_L, 32'h0);
        checkOutput("reset_outR", rx_bus.out_R, 32'h0);
        reset_n = 1'b1;
        idle_cycles(5);

        // Single frame at the 48 kHz bit clock.
        t0 = tick_count;
        e0 = err_count;
        applyStimulus(24'h123456, 24'hFEDCBA);
        idle_cycles(20);
        checkOutput("frame1_ticks", 32'(tick_count - t0), 32'd1);
        checkOutput("frame1_outL", rx_bus.out_L, 32'h12345600);
        checkOutput("frame1_outR", rx_bus.out_R, 32'hFEDCBA00);
        checkOutput("frame1_err", 32'(err_count - e0), 32'd0);

        // Full-scale frames; a faster bit clock keeps the run short.
        bclk_half = 100;
        t0 = tick_count;
        e0 = err_count;
        for (int f = 0; f < 64; f++) applyStimulus(24'h7FFFFF, 24'h800000);
        idle_cycles(20);
        checkOutput("fs_ticks", 32'(tick_count - t0), 32'd64);
        checkOutput("fs_outL", rx_bus.out_L, 32'h7FFFFF00);
        checkOutput("fs_outR", rx_bus.out_R, 32'h80000000);
        checkOutput("fs_err", 32'(err_count - e0), 32'd0);

        // Left word cut short to 20 BCLKs: one error pulse, no tick, hold.
        t0 = tick_count;
        e0 = err_count;
        i2s_slot(1'b0, 24'h0A0B0C, 20);
        i2s_slot(1'b1, 24'h112233, 32);
        idle_cycles(20);
        checkOutput("trunc_err", 32'(err_count - e0), 32'd1);
        checkOutput("trunc_ticks", 32'(tick_count - t0), 32'd0);
        checkOutput("trunc_holdL", rx_bus.out_L, 32'h7FFFFF00);
        t0 = tick_count;
        applyStimulus(24'h0A0B0C, 24'h112233);
        idle_cycles(20);
        checkOutput("resync_ticks", 32'(tick_count - t0), 32'd1);
        checkOutput("resync_outL", rx_bus.out_L, 32'h0A0B0C00);
        checkOutput("resync_outR", rx_bus.out_R, 32'h11223300);

        // Reset in the middle of the right word.
        t0 = tick_count;
        e0 = err_count;
        i2s_slot(1'b0, 24'hABCDEF, 32);
        i2s_slot(1'b1, 24'h654321, 10);
        reset_n = 1'b0;
        idle_cycles(4);
        checkOutput("midrst_outL", rx_bus.out_L, 32'h0);
        checkOutput("midrst_outR", rx_bus.out_R, 32'h0);
        checkOutput("midrst_tick", {31'b0, rx_bus.tick}, 32'd0);
        reset_n = 1'b1;
        i2s_slot(1'b1, 24'h000000, 22);
        idle_cycles(20);
        checkOutput("postrst_ticks", 32'(tick_count - t0), 32'd0);
        checkOutput("postrst_outL", rx_bus.out_L, 32'h0);
        applyStimulus(24'h000001, 24'h000002);
        idle_cycles(20);
        checkOutput("postrst_frame_ticks", 32'(tick_count - t0), 32'd1);
        checkOutput("postrst_frame_outL", rx_bus.out_L, 32'h00000100);
        checkOutput("postrst_frame_outR", rx_bus.out_R, 32'h00000200);
        checkOutput("postrst_err", 32'(err_count - e0), 32'd0);

        // enable dropped mid left word and held low for three frames.
        t0 = tick_count;
        e0 = err_count;
        i2s_slot(1'b0, 24'h111111, 10);
        enable = 1'b0;
        i2s_slot(1'b0, 24'h111111, 22);
        i2s_slot(1'b1, 24'h222222, 32);
        applyStimulus(24'h333333, 24'h444444);
        applyStimulus(24'h555555, 24'h666666);
        idle_cycles(20);
        checkOutput("dis_ticks", 32'(tick_count - t0), 32'd0);
        checkOutput("dis_err", 32'(err_count - e0), 32'd0);
        checkOutput("dis_holdL", rx_bus.out_L, 32'h00000100);
        checkOutput("dis_holdR", rx_bus.out_R, 32'h00000200);
        enable = 1'b1;
        idle_cycles(5);
        applyStimulus(24'h2468AC, 24'h13579B);
        idle_cycles(20);
        checkOutput("reen_ticks", 32'(tick_count - t0), 32'd1);
        checkOutput("reen_outL", rx_bus.out_L, 32'h2468AC00);
        checkOutput("reen_outR", rx_bus.out_R, 32'h13579B00);
        checkOutput("reen_err", 32'(err_count - e0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
